// File: rtl/nr_fetch_pkg.sv
// nr_fetch_pkg: shared types and constants for the nr_fetch_pc fetch stage.
//   state_t        : fetch-stage control states (FETCH, DRAIN, HOLD, HALTED)
//   pc_sel_t       : next-PC source selector used by nr_next_pc
//   NR_HALT_OPCODE : halt instruction pattern, all ones, sliced to INSTR_W
//                    by the user (only acted on when NR_FETCH_HALT_EN is set)
//   NR_ADDR_W / NR_INSTR_W : default widths
package nr_fetch_pkg;

  localparam int unsigned NR_ADDR_W  = 8;
  localparam int unsigned NR_INSTR_W = 8;

  // Wide all-ones constant so any INSTR_W up to 64 can take a slice of it.
  localparam logic [63:0] NR_HALT_OPCODE = '1;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DRAIN  = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    PC_HOLD    = 2'd0,
    PC_INC     = 2'd1,
    PC_TARGET  = 2'd2,
    PC_PENDING = 2'd3
  } pc_sel_t;

endpackage

// File: rtl/nr_fetch_pc_next_pc.sv
// nr_next_pc: combinational next-PC selection for the fetch stage.
// Ports:
//   pc          in  ADDR_W  current PC
//   flux_target in  ADDR_W  redirect target
//   pending     in  ADDR_W  redirect target saved while draining
//   sel         in  pc_sel_t  source select (hold / +1 / target / pending)
//   next_pc     out ADDR_W  selected next PC (increment wraps mod 2^ADDR_W)
module nr_next_pc
  import nr_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = NR_ADDR_W
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] flux_target,
  input  logic [ADDR_W-1:0] pending,
  input  pc_sel_t           sel,
  output logic [ADDR_W-1:0] next_pc
);

  always_comb begin
    next_pc = pc;
    unique case (sel)
      PC_HOLD:    next_pc = pc;
      PC_INC:     next_pc = pc + ADDR_W'(1);
      PC_TARGET:  next_pc = flux_target;
      PC_PENDING: next_pc = pending;
      default:    next_pc = pc;
    endcase
  end

endmodule

// File: rtl/nr_fetch_pc.sv
// nr_fetch_pc: program counter and instruction-fetch stage.
// Issues req/ack fetches to instruction memory, presents one instruction at a
// time to decode over valid/ready, and restarts at a redirect target on flux.
// Build option: NR_FETCH_HALT_EN adds a HALTED state entered when the halt
// opcode is transferred to decode; without it halted is tied low.
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   flux, flux_target   taken-flow redirect request and target
//   imem_req, imem_addr fetch request/address (address stable until ack)
//   imem_ack, imem_data memory response
//   instr_valid, instr_ready  handshake toward decode
//   instr, instr_pc     held instruction and its address
//   halted              fetch stopped on halt opcode
module nr_fetch_pc
  import nr_fetch_pkg::*;
#(
  parameter int unsigned          ADDR_W   = NR_ADDR_W,
  parameter int unsigned          INSTR_W  = NR_INSTR_W,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flux,
  input  logic [ADDR_W-1:0]  flux_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               halted
);

  state_t              state, state_n;
  pc_sel_t             pc_sel;
  logic [ADDR_W-1:0]   pc, pc_n;
  logic [ADDR_W-1:0]   pending, pending_n;
  logic                load_instr;
  logic                clr_valid;
  logic                halt_hit;

  nr_next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
    .pc          (pc),
    .flux_target (flux_target),
    .pending     (pending),
    .sel         (pc_sel),
    .next_pc     (pc_n)
  );

`ifdef NR_FETCH_HALT_EN
  assign halt_hit = (instr == NR_HALT_OPCODE[INSTR_W-1:0]);
  assign halted   = (state == HALTED);
`else
  assign halt_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  // Request is decoded from state but forced low during reset so an
  // outstanding fetch is visibly abandoned in the reset cycle.
  assign imem_req  = !rst && ((state == FETCH) || (state == DRAIN));
  assign imem_addr = pc;

  always_comb begin
    state_n    = state;
    pc_sel     = PC_HOLD;
    pending_n  = pending;
    load_instr = 1'b0;
    clr_valid  = 1'b0;
    unique case (state)
      FETCH: begin
        if (imem_ack && !flux) begin
          load_instr = 1'b1;
          pc_sel     = PC_INC;
          state_n    = HOLD;
        end else if (imem_ack && flux) begin
          pc_sel     = PC_TARGET;
        end else if (flux) begin
          pending_n  = flux_target;
          state_n    = DRAIN;
        end
      end
      DRAIN: begin
        // Wrong-path word still in flight; keep the request up until it
        // lands, remembering only the most recent redirect.
        if (flux) pending_n = flux_target;
        if (imem_ack) begin
          pc_sel  = flux ? PC_TARGET : PC_PENDING;
          state_n = FETCH;
        end
      end
      HOLD: begin
        if (flux) begin
          clr_valid = 1'b1;
          pc_sel    = PC_TARGET;
          state_n   = FETCH;
        end else if (instr_ready) begin
          clr_valid = 1'b1;
          state_n   = halt_hit ? HALTED : FETCH;
        end
      end
`ifdef NR_FETCH_HALT_EN
      HALTED: begin
        if (flux) begin
          pc_sel  = PC_TARGET;
          state_n = FETCH;
        end
      end
`endif
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      pending     <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      pending <= pending_n;
      if (load_instr) begin
        instr       <= imem_data;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
      end else if (clr_valid) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nr_fetch_pc.sv
// tb_nr_fetch_pc: directed scenarios followed by randomized traffic, checked
// each cycle against a transaction-level model of the fetch stage.
module tb_nr_fetch_pc;

  logic       clk = 1'b0;
  logic       rst, flux, imem_req, imem_ack, instr_valid, instr_ready, halted;
  logic [7:0] flux_target, imem_addr, imem_data, instr, instr_pc;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  logic [7:0] mem [256];

  // Model: "have" = a word is held for decode; "squash" = a wrong-path
  // request is still outstanding; otherwise we are requesting at m_pc.
  bit         m_have, m_squash, m_halt;
  logic [7:0] m_pc, m_redirect, m_instr, m_ipc;

  nr_fetch_pc #(.ADDR_W(8), .INSTR_W(8), .RESET_PC(8'h10)) dut (
    .clk         (clk),
    .rst         (rst),
    .flux        (flux),
    .flux_target (flux_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_edge(input bit rs, input bit f, input logic [7:0] t,
                            input bit a, input bit r, input logic [7:0] d);
    if (rs) begin
      m_have = 0; m_squash = 0; m_halt = 0; m_pc = 8'h10;
      m_redirect = 0; m_instr = 0; m_ipc = 0;
    end else if (m_have) begin
      if (f) begin
        m_have = 0; m_pc = t;
      end else if (r) begin
        m_have = 0;
`ifdef NR_FETCH_HALT_EN
        if (m_instr == 8'hFF) m_halt = 1;
`endif
      end
    end else if (m_halt) begin
      if (f) begin m_halt = 0; m_pc = t; end
    end else if (m_squash) begin
      if (f) m_redirect = t;
      if (a) begin m_pc = m_redirect; m_squash = 0; end
    end else begin
      if (a && !f) begin
        m_have = 1; m_instr = d; m_ipc = m_pc; m_pc = m_pc + 8'd1;
      end else if (a) begin
        m_pc = t;
      end else if (f) begin
        m_squash = 1; m_redirect = t;
      end
    end
  endtask

  task automatic step(input bit f, input logic [7:0] t, input bit a,
                      input bit r, input bit rs = 1'b0);
    logic [7:0] d;
    d = a ? mem[m_pc] : 8'($urandom);
    rst = rs; flux = f; flux_target = t; imem_ack = a; instr_ready = r;
    imem_data = d;
    @(negedge clk);
    if (rs) begin
      chk("req_in_reset", 32'(imem_req), 32'(0));
    end else begin
      chk("imem_req", 32'(imem_req), 32'(!m_have && !m_halt));
      if (!m_have && !m_halt) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
      chk("instr_valid", 32'(instr_valid), 32'(m_have));
      if (m_have) begin
        chk("instr", 32'(instr), 32'(m_instr));
        chk("instr_pc", 32'(instr_pc), 32'(m_ipc));
      end
      chk("halted", 32'(halted), 32'(m_halt));
    end
    @(posedge clk);
    model_edge(rs, f, t, a, r, d);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 254));
`ifdef NR_FETCH_HALT_EN
    mem[3] = 8'hFF;
`endif
    rst = 1; flux = 0; flux_target = 0; imem_ack = 0; instr_ready = 0; imem_data = 0;
    @(posedge clk); #1;
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);
    chk("reset_valid", 32'(instr_valid), 32'(0));
    chk("reset_instr", 32'(instr), 32'(0));
    chk("reset_instr_pc", 32'(instr_pc), 32'(0));
    chk("reset_halted", 32'(halted), 32'(0));
    chk("first_addr", 32'(imem_addr), 32'h10);

    // Back-to-back fetch/accept from 0x10.
    repeat (6) step(0, 8'h00, 1, 1);
    chk("seq_addr", 32'(imem_addr), 32'h13);

    // Wrap from 0xFF.
    step(0, 8'h00, 1, 0);
    step(1, 8'hFF, 0, 0);
    step(0, 8'h00, 1, 1);
    step(0, 8'h00, 0, 1);
    chk("wrap_addr", 32'(imem_addr), 32'h00);

    // Delayed ack with two redirects while draining; latest wins.
    step(1, 8'h40, 0, 0);
    step(1, 8'h50, 0, 0);
    chk("drain_addr", 32'(imem_addr), 32'h00);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 1, 0);
    chk("drain_valid", 32'(instr_valid), 32'(0));
    chk("drain_target", 32'(imem_addr), 32'h50);

    // Redirect in HOLD beats instr_ready.
    step(1, 8'h05, 1, 0);
    step(0, 8'h00, 1, 0);
    chk("hold_pc", 32'(instr_pc), 32'h05);
    step(1, 8'h20, 0, 1);
    chk("flux_valid", 32'(instr_valid), 32'(0));
    chk("flux_addr", 32'(imem_addr), 32'h20);

    // Stall in HOLD.
    step(0, 8'h00, 1, 0);
    repeat (5) step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 1);

`ifdef NR_FETCH_HALT_EN
    step(1, 8'h03, 0, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    chk("halt_instr", 32'(instr), 32'hFF);
    step(0, 8'h00, 0, 1);
    chk("halted_set", 32'(halted), 32'(1));
    repeat (3) step(0, 8'h00, 1, 1);
    step(1, 8'h00, 0, 0);
    chk("halt_exit", 32'(halted), 32'(0));
    chk("halt_exit_addr", 32'(imem_addr), 32'h00);
`endif

    repeat (3000) begin
      step(($urandom % 5) == 0, 8'($urandom), ($urandom % 3) != 0,
           ($urandom % 2) == 0, ($urandom % 200) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
